// File: rtl/ritc_autotrain_ctrl.sv
// Automatic per-bit IDELAY eye centring and bitslip alignment master for the dual-RITC datapath bus.
// Optional eye log (define AUTOTRAIN_EYE_LOG_EN): per-bit {eye_len, tap} readable via log_addr_i/log_dat_o.
module ritc_autotrain_ctrl #(
  parameter int          NUM_CH        = 6,
  parameter int          NUM_BIT       = 12,
  parameter logic [7:0]  TRAIN_PATTERN = 8'hB4,
  parameter int          SETTLE_CYCLES = 64,
  parameter int          READS         = 8,
  parameter int          MAX_SLIP      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [NUM_CH*NUM_BIT-1:0] fail_o,
  output logic [6:0]                fail_count_o,
  output logic [6:0]                cur_sel_o,
  output logic                      bus_sel_o,
  output logic                      bus_wr_o,
  output logic [3:0]                bus_addr_o,
  output logic [31:0]               bus_dat_o,
  input  logic [31:0]               bus_dat_i
`ifdef AUTOTRAIN_EYE_LOG_EN
  ,
  input  logic [6:0]                log_addr_i,
  output logic [9:0]                log_dat_o
`endif
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SELECT  = 4'd1;
  localparam logic [3:0] S_SET_TAP = 4'd2;
  localparam logic [3:0] S_SETTLE  = 4'd3;
  localparam logic [3:0] S_SAMPLE  = 4'd4;
  localparam logic [3:0] S_EVAL    = 4'd5;
  localparam logic [3:0] S_CENTER  = 4'd6;
  localparam logic [3:0] S_CHECK   = 4'd7;
  localparam logic [3:0] S_SLIP    = 4'd8;
  localparam logic [3:0] S_FAIL    = 4'd9;
  localparam logic [3:0] S_NEXT    = 4'd10;
  localparam logic [3:0] S_DONE    = 4'd11;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] READ_LAST   = 16'(READS - 1);
  localparam logic [3:0]  SLIP_LIMIT  = 4'(MAX_SLIP);
  localparam logic [2:0]  CH_LAST     = 3'(NUM_CH - 1);
  localparam logic [3:0]  BIT_LAST    = 4'(NUM_BIT - 1);
  localparam int          NUM_SEL     = NUM_CH * NUM_BIT;

  logic [3:0]  state_reg;
  logic [2:0]  ch_reg;
  logic [3:0]  bit_reg;
  logic [4:0]  tap_reg;
  logic [15:0] cnt_reg;
  logic        to_check_reg;
  logic [7:0]  first_reg;
  logic        stable_reg;
  logic        match_reg;
  logic [4:0]  run_start_reg;
  logic [5:0]  run_len_reg;
  logic [4:0]  best_start_reg;
  logic [5:0]  best_len_reg;
  logic [3:0]  slip_cnt_reg;
  logic [6:0]  fail_count_reg;
  logic        done_reg;

  logic [7:0]  rd_byte;
  logic [6:0]  sel;
  logic [6:0]  flat_idx;
  logic        accept_start;
  logic        fail_set;
  logic [5:0]  run_len_next;
  logic [4:0]  run_start_next;
  logic [4:0]  center_tap;
  logic        check_all_match;
  logic        unused_dat;

  assign rd_byte      = bus_dat_i[7:0];
  assign unused_dat   = ^bus_dat_i[31:8];
  assign sel          = {ch_reg, bit_reg};
  assign flat_idx     = {4'd0, ch_reg} * 7'(NUM_BIT) + {3'd0, bit_reg};
  assign accept_start = (state_reg == S_IDLE) && start_i;
  assign fail_set     = (state_reg == S_FAIL);

  // A good tap extends the current run; the first good tap after a bad one opens a new run.
  assign run_len_next   = run_len_reg + 6'd1;
  assign run_start_next = (run_len_reg == 6'd0) ? tap_reg : run_start_reg;
  assign center_tap     = (best_len_reg == 6'd0) ? 5'd0 : best_start_reg + best_len_reg[5:1];
  assign check_all_match = ((cnt_reg == 16'd0) || match_reg) && (rd_byte == TRAIN_PATTERN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= S_IDLE;
      ch_reg         <= 3'd0;
      bit_reg        <= 4'd0;
      tap_reg        <= 5'd0;
      cnt_reg        <= 16'd0;
      to_check_reg   <= 1'b0;
      first_reg      <= 8'd0;
      stable_reg     <= 1'b0;
      match_reg      <= 1'b0;
      run_start_reg  <= 5'd0;
      run_len_reg    <= 6'd0;
      best_start_reg <= 5'd0;
      best_len_reg   <= 6'd0;
      slip_cnt_reg   <= 4'd0;
      fail_count_reg <= 7'd0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            done_reg       <= 1'b0;
            fail_count_reg <= 7'd0;
            ch_reg         <= 3'd0;
            bit_reg        <= 4'd0;
            state_reg      <= S_SELECT;
          end
        end
        S_SELECT: begin
          tap_reg        <= 5'd0;
          run_len_reg    <= 6'd0;
          run_start_reg  <= 5'd0;
          best_len_reg   <= 6'd0;
          best_start_reg <= 5'd0;
          slip_cnt_reg   <= 4'd0;
          state_reg      <= S_SET_TAP;
        end
        S_SET_TAP: begin
          to_check_reg <= 1'b0;
          cnt_reg      <= 16'd0;
          state_reg    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= 16'd0;
            state_reg <= to_check_reg ? S_CHECK : S_SAMPLE;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_SAMPLE: begin
          if (cnt_reg == 16'd0) begin
            first_reg  <= rd_byte;
            stable_reg <= 1'b1;
          end else if (rd_byte != first_reg) begin
            stable_reg <= 1'b0;
          end
          if (cnt_reg == READ_LAST) begin
            cnt_reg   <= 16'd0;
            state_reg <= S_EVAL;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_EVAL: begin
          if (stable_reg) begin
            run_len_reg   <= run_len_next;
            run_start_reg <= run_start_next;
            // Strictly longer only, so an equal-length later run never displaces the earlier one.
            if (run_len_next > best_len_reg) begin
              best_len_reg   <= run_len_next;
              best_start_reg <= run_start_next;
            end
          end else begin
            run_len_reg <= 6'd0;
          end
          if (tap_reg == 5'd31) begin
            state_reg <= S_CENTER;
          end else begin
            tap_reg   <= tap_reg + 5'd1;
            state_reg <= S_SET_TAP;
          end
        end
        S_CENTER: begin
          tap_reg      <= center_tap;
          to_check_reg <= 1'b1;
          cnt_reg      <= 16'd0;
          state_reg    <= (best_len_reg == 6'd0) ? S_FAIL : S_SETTLE;
        end
        S_CHECK: begin
          match_reg <= check_all_match;
          if (cnt_reg == READ_LAST) begin
            cnt_reg <= 16'd0;
            if (check_all_match) begin
              state_reg <= S_NEXT;
            end else if (slip_cnt_reg < SLIP_LIMIT) begin
              state_reg <= S_SLIP;
            end else begin
              state_reg <= S_FAIL;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_SLIP: begin
          slip_cnt_reg <= slip_cnt_reg + 4'd1;
          to_check_reg <= 1'b1;
          cnt_reg      <= 16'd0;
          state_reg    <= S_SETTLE;
        end
        S_FAIL: begin
          fail_count_reg <= fail_count_reg + 7'd1;
          state_reg      <= S_NEXT;
        end
        S_NEXT: begin
          if (bit_reg == BIT_LAST) begin
            bit_reg <= 4'd0;
            if (ch_reg == CH_LAST) begin
              ch_reg    <= 3'd0;
              state_reg <= S_DONE;
            end else begin
              ch_reg    <= ch_reg + 3'd1;
              state_reg <= S_SELECT;
            end
          end else begin
            bit_reg   <= bit_reg + 4'd1;
            state_reg <= S_SELECT;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_fail
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          fail_o[gi] <= 1'b0;
        end else if (accept_start) begin
          fail_o[gi] <= 1'b0;
        end else if (fail_set && (flat_idx == 7'(gi))) begin
          fail_o[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Bus outputs decode straight from registered state so a reset drops them in the same cycle.
  always_comb begin
    bus_sel_o  = 1'b0;
    bus_wr_o   = 1'b0;
    bus_addr_o = 4'd0;
    bus_dat_o  = 32'd0;
    case (state_reg)
      S_SELECT, S_SLIP: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = 4'd2;
        bus_dat_o  = {1'b0, (state_reg == S_SLIP), 7'h0, sel, 16'h0};
      end
      S_SET_TAP: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = 4'd4;
        bus_dat_o  = {1'b1, 8'h0, sel, 11'h0, tap_reg};
      end
      S_CENTER: begin
        bus_sel_o  = 1'b1;
        bus_wr_o   = 1'b1;
        bus_addr_o = 4'd4;
        bus_dat_o  = {1'b1, 8'h0, sel, 11'h0, center_tap};
      end
      S_SAMPLE, S_CHECK: begin
        bus_sel_o  = 1'b1;
        bus_addr_o = 4'd2;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_reg != S_IDLE);
  assign done_o       = done_reg;
  assign fail_count_o = fail_count_reg;
  assign cur_sel_o    = sel;

`ifdef AUTOTRAIN_EYE_LOG_EN
  logic [9:0] log_mem [NUM_SEL];

  always_ff @(posedge clk_i) begin
    if (state_reg == S_NEXT) begin
      log_mem[flat_idx] <= {best_len_reg[4:0], center_tap};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      log_dat_o <= 10'd0;
    end else if (log_addr_i < 7'(NUM_SEL)) begin
      log_dat_o <= log_mem[log_addr_i];
    end else begin
      log_dat_o <= 10'd0;
    end
  end
`endif

endmodule

// File: tb/tb_ritc_autotrain_ctrl.sv
// Scoreboard bench: a datapath model answers reads from per-bit eye masks and slip targets,
// an eye/slip reference predicts every bus write and the final fail vector.
module tb_ritc_autotrain_ctrl;

  localparam int NB = 72;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [71:0] fail;
  logic [6:0]  fail_count;
  logic [6:0]  cur_sel;
  logic        bus_sel;
  logic        bus_wr;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdat;
  logic [31:0] bus_rdat;
`ifdef AUTOTRAIN_EYE_LOG_EN
  logic [6:0]  log_addr;
  logic [9:0]  log_dat;
`endif

  ritc_autotrain_ctrl #(
    .SETTLE_CYCLES(2),
    .READS(3)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .fail_o       (fail),
    .fail_count_o (fail_count),
    .cur_sel_o    (cur_sel),
    .bus_sel_o    (bus_sel),
    .bus_wr_o     (bus_wr),
    .bus_addr_o   (bus_addr),
    .bus_dat_o    (bus_wdat),
    .bus_dat_i    (bus_rdat)
`ifdef AUTOTRAIN_EYE_LOG_EN
    ,
    .log_addr_i   (log_addr),
    .log_dat_o    (log_dat)
`endif
  );

  // ---------------- datapath model ----------------
  logic [31:0] mask [NB];
  int          need [NB];
  logic [4:0]  dp_tap [NB];
  int          slips_done [NB];
  logic [6:0]  trn_sel;
  logic        model_clr;
  logic [7:0]  noise = 8'd0;
  int          rd_idx;

  function automatic int sel2idx(input logic [6:0] s);
    return int'(s[6:4]) * 12 + int'(s[3:0]);
  endfunction

  function automatic logic [6:0] idx2sel(input int i);
    logic [2:0] c;
    logic [3:0] b;
    c = 3'(i / 12);
    b = 4'(i % 12);
    return {c, b};
  endfunction

  always @(posedge clk) begin
    noise <= noise + 8'd1;
    if (model_clr) begin
      trn_sel <= 7'd0;
      for (int i = 0; i < NB; i++) begin
        slips_done[i] <= 0;
        dp_tap[i]     <= 5'd0;
      end
    end else if (rst_n && bus_sel && bus_wr) begin
      if (bus_addr == 4'd2) begin
        trn_sel <= bus_wdat[22:16];
        if (bus_wdat[30]) slips_done[sel2idx(bus_wdat[22:16])] <= slips_done[sel2idx(bus_wdat[22:16])] + 1;
      end else if (bus_addr == 4'd4 && bus_wdat[31]) begin
        dp_tap[sel2idx(bus_wdat[22:16])] <= bus_wdat[4:0];
      end
    end
  end

  // Inside the eye the readback is stable (pattern once slipped enough); outside it changes every cycle.
  always_comb begin
    rd_idx   = sel2idx(trn_sel);
    bus_rdat = {noise, noise, noise, 8'h00};
    if (rd_idx < NB) begin
      if (mask[rd_idx][dp_tap[rd_idx]])
        bus_rdat[7:0] = (slips_done[rd_idx] == need[rd_idx]) ? 8'hB4 : 8'h4B;
      else
        bus_rdat[7:0] = noise;
    end
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q [$];
  logic [71:0] exp_fail;
  int          exp_fcount;
  int          checks = 0;
  int          errors = 0;
  int          wr_count, slip25, slip5b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] trn_word(input logic [6:0] s, input logic slip);
    return {1'b0, slip, 7'h0, s, 16'h0};
  endfunction

  function automatic logic [31:0] dly_word(input logic [6:0] s, input logic [4:0] t);
    return {1'b1, 8'h0, s, 11'h0, t};
  endfunction

  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (model_clr) begin
        wr_count = 0;
        slip25   = 0;
        slip5b   = 0;
      end else if (rst_n) begin
        if (bus_sel && bus_wr) begin
          wr_count++;
          if (bus_addr == 4'd2 && bus_wdat[30] && bus_wdat[22:16] == 7'h25) slip25++;
          if (bus_addr == 4'd2 && bus_wdat[30] && bus_wdat[22:16] == 7'h5B) slip5b++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected none", {bus_addr, bus_wdat});
          end else begin
            e = exp_q.pop_front();
            chk("bus_write", {bus_addr, bus_wdat}, e);
            $display("write addr=%0d dat=%08h", bus_addr, bus_wdat);
          end
        end else if (bus_sel) begin
          chk("read_addr", bus_addr, 4'd2);
        end else begin
          chk("idle_bus", {bus_wr, bus_addr, bus_wdat}, 37'd0);
        end
      end
    end
  end

  // Reference: longest run of stable taps, lowest start on ties, centre = start + len/2.
  task automatic build_expected();
    logic [6:0] s;
    logic [4:0] ctr;
    int bl, bs, l, nsl;
    exp_fail   = '0;
    exp_fcount = 0;
    for (int i = 0; i < NB; i++) begin
      s = idx2sel(i);
      exp_q.push_back({4'd2, trn_word(s, 1'b0)});
      for (int t = 0; t < 32; t++) exp_q.push_back({4'd4, dly_word(s, 5'(t))});
      bl = 0;
      bs = 0;
      for (int st = 0; st < 32; st++) begin
        l = 0;
        while (st + l < 32 && mask[i][st + l]) l++;
        if (l > bl) begin
          bl = l;
          bs = st;
        end
      end
      if (bl == 0) begin
        exp_q.push_back({4'd4, dly_word(s, 5'd0)});
        exp_fail[i] = 1'b1;
        exp_fcount++;
      end else begin
        ctr = 5'((bs + bl / 2) % 32);
        exp_q.push_back({4'd4, dly_word(s, ctr)});
        nsl = (need[i] <= 8) ? need[i] : 8;
        for (int k = 0; k < nsl; k++) exp_q.push_back({4'd2, trn_word(s, 1'b1)});
        if (need[i] > 8) begin
          exp_fail[i] = 1'b1;
          exp_fcount++;
        end
      end
    end
  endtask

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic setup_uniform();
    for (int i = 0; i < NB; i++) begin
      mask[i] = range_mask(8, 20);
      need[i] = 0;
    end
  endtask

  task automatic setup_random();
    int lo, hi;
    for (int i = 0; i < NB; i++) begin
      lo = $urandom_range(0, 28);
      hi = lo + $urandom_range(0, 31 - lo);
      mask[i] = range_mask(lo, hi);
      if ($urandom_range(0, 3) == 0) begin
        lo = $urandom_range(0, 31);
        hi = lo + $urandom_range(0, 31 - lo);
        mask[i] = mask[i] | range_mask(lo, hi);
      end
      need[i] = $urandom_range(0, 4);
    end
    mask[0]  = range_mask(2, 5) | range_mask(20, 23);
    mask[1]  = range_mask(2, 5) | range_mask(20, 24);
    need[2]  = 9;
    need[29] = 3;
    mask[71] = 32'd0;
  endtask

  task automatic model_reset();
    @(negedge clk);
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic run_and_wait(input string name, input bit inject);
    bit got;
    got = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (inject && n == 500) begin
        chk({name, "_busy_before_pulse"}, busy, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_after_pulse"}, busy, 1'b1);
        chk({name, "_done_after_pulse"}, done, 1'b0);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_timeout"}, got, 1'b1);
  endtask

  task automatic final_checks(input string name);
    repeat (2) @(negedge clk);
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_fail_vec"}, fail, exp_fail);
    chk({name, "_fail_count"}, fail_count, 7'(exp_fcount));
    chk({name, "_queue_left"}, exp_q.size(), 0);
    $display("%s complete: fail_count=%0d writes=%0d", name, fail_count, wr_count);
  endtask

  initial begin
    bit found;
    rst_n     = 1'b0;
    start     = 1'b0;
    model_clr = 1'b0;
`ifdef AUTOTRAIN_EYE_LOG_EN
    log_addr  = 7'd0;
`endif
    for (int i = 0; i < NB; i++) begin
      mask[i] = 32'd0;
      need[i] = 0;
    end
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fail", fail, 72'd0);
    chk("rst_fail_count", fail_count, 7'd0);
    chk("rst_cur_sel", cur_sel, 7'd0);
    chk("rst_bus", {bus_sel, bus_wr, bus_addr, bus_wdat}, 38'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform eye 8..20, no slips needed; a start pulse mid-run must be ignored.
    setup_uniform();
    model_reset();
    build_expected();
    run_and_wait("uniform", 1'b1);
    final_checks("uniform");
    chk("uniform_write_total", wr_count, 72 * 33 + 72);
    for (int i = 0; i < NB; i++) chk($sformatf("uniform_tap_%0d", i), dp_tap[i], 5'd14);
`ifdef AUTOTRAIN_EYE_LOG_EN
    log_addr = 7'd0;
    @(negedge clk);
    chk("log_entry0", log_dat, {5'd13, 5'd14});
`endif

    // Random eyes plus directed slip, no-eye, tie and slip-exhaustion bits.
    setup_random();
    model_reset();
    build_expected();
    run_and_wait("random", 1'b0);
    final_checks("random");
    chk("slips_sel25", slip25, 3);
    chk("pass_sel25", fail[29], 1'b0);
    chk("fail_bit71", fail[71], 1'b1);
    chk("tap_bit71", dp_tap[71], 5'd0);
    chk("slips_sel5b", slip5b, 0);
    chk("tie_tap_bit0", dp_tap[0], 5'd4);
    chk("long_tap_bit1", dp_tap[1], 5'd22);
    chk("slip_exhaust_bit2", fail[2], 1'b1);

    // Reset while sampling bit 30, then a clean restart.
    setup_random();
    model_reset();
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (cur_sel == 7'h26 && bus_sel && !bus_wr) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_bit30_sample", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bus", {bus_sel, bus_wr, bus_addr, bus_wdat}, 38'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_fail_count", fail_count, 7'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    build_expected();
    run_and_wait("restart", 1'b0);
    final_checks("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
